// File: rtl/csi2_packet_parser.sv
// CSI-2 single-lane packet parser. It splits one HS burst into the
// packet header, a registered payload stream and the CRC-16 check,
// and flags bursts that end before the packet is complete.
`timescale 1ns/1ps

module csi2_packet_parser #(
  parameter bit CHECK_CRC = 1'b1
) (
  input  logic        clock_p,
  input  logic        reset,
  input  logic [7:0]  data,
  input  logic        enable,
  output logic [1:0]  virtual_channel,
  output logic [5:0]  data_type,
  output logic [15:0] word_count,
  output logic [7:0]  ecc,
  output logic        header_valid,
  output logic [7:0]  payload_data,
  output logic        payload_enable,
  output logic        payload_last,
  output logic        crc_valid,
  output logic        crc_error,
  output logic        packet_abort
);

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, CRC, DRAIN} state_t;

  state_t      state;
  // Set once enable has been seen low since reset. A burst already in
  // flight when reset is released is drained rather than parsed.
  logic        armed;
  logic [1:0]  hdr_cnt;
  logic [7:0]  hdr_di;
  logic [7:0]  hdr_wcl;
  logic [7:0]  hdr_wcm;
  logic [15:0] pay_cnt;
  logic [15:0] crc;
  logic        crc_cnt;
  logic [7:0]  crc_lsb;

  // CRC-16 (x^16+x^12+x^5+1) in reflected form, one byte, LSB first.
  function automatic logic [15:0] crc16_update(input logic [15:0] c,
                                               input logic [7:0]  d);
    logic [15:0] r;
    // NOTE: blocking assignments are right here: r is a combinational
    // temporary stepped eight times within one call, not a register.
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Packet FSM with all outputs registered; event outputs default low
  // every cycle so each one is a single-cycle pulse.
  always_ff @(posedge clock_p or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      armed           <= 1'b0;
      hdr_cnt         <= '0;
      hdr_di          <= '0;
      hdr_wcl         <= '0;
      hdr_wcm         <= '0;
      pay_cnt         <= '0;
      crc             <= '0;
      crc_cnt         <= 1'b0;
      crc_lsb         <= '0;
      virtual_channel <= '0;
      data_type       <= '0;
      word_count      <= '0;
      ecc             <= '0;
      header_valid    <= 1'b0;
      payload_data    <= '0;
      payload_enable  <= 1'b0;
      payload_last    <= 1'b0;
      crc_valid       <= 1'b0;
      crc_error       <= 1'b0;
      packet_abort    <= 1'b0;
    end else begin
      header_valid   <= 1'b0;
      payload_enable <= 1'b0;
      payload_last   <= 1'b0;
      crc_valid      <= 1'b0;
      packet_abort   <= 1'b0;
      if (!enable) armed <= 1'b1;

      case (state)
        IDLE: begin
          if (enable) begin
            if (armed) begin
              // The byte that opens the burst is the data identifier.
              hdr_di  <= data;
              hdr_cnt <= 2'd1;
              state   <= HEADER;
            end else begin
              state <= DRAIN;
            end
          end
        end

        HEADER: begin
          if (!enable) begin
            packet_abort <= 1'b1;
            state        <= IDLE;
          end else begin
            hdr_cnt <= hdr_cnt + 2'd1;
            if (hdr_cnt == 2'd1) hdr_wcl <= data;
            if (hdr_cnt == 2'd2) hdr_wcm <= data;
            if (hdr_cnt == 2'd3) begin
              virtual_channel <= hdr_di[7:6];
              data_type       <= hdr_di[5:0];
              word_count      <= {hdr_wcm, hdr_wcl};
              ecc             <= data;
              header_valid    <= 1'b1;
              crc             <= 16'hFFFF;
              pay_cnt         <= '0;
              crc_cnt         <= 1'b0;
              if (hdr_di[5:4] == 2'b00)              state <= DRAIN;
              else if ({hdr_wcm, hdr_wcl} == 16'h0) state <= CRC;
              else                                   state <= PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
          if (!enable) begin
            packet_abort <= 1'b1;
            state        <= IDLE;
          end else begin
            payload_data   <= data;
            payload_enable <= 1'b1;
            crc            <= crc16_update(crc, data);
            pay_cnt        <= pay_cnt + 16'd1;
            if (pay_cnt + 16'd1 == word_count) begin
              payload_last <= 1'b1;
              state        <= CRC;
            end
          end
        end

        CRC: begin
          if (!enable) begin
            packet_abort <= 1'b1;
            state        <= IDLE;
          end else if (!crc_cnt) begin
            crc_lsb <= data;
            crc_cnt <= 1'b1;
          end else begin
            crc_valid <= 1'b1;
            crc_error <= (CHECK_CRC != 1'b0) && ({data, crc_lsb} != crc);
            state     <= DRAIN;
          end
        end

        DRAIN: begin
          if (!enable) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csi2_packet_parser.sv
// Scoreboard bench for csi2_packet_parser: directed bursts push their
// expected header/payload/CRC/abort events into queues, and a monitor
// pops and compares whenever the parser raises an output event.
`timescale 1ns/1ps

module tb_csi2_packet_parser;

  logic        clock_p = 1'b0;
  logic        reset   = 1'b1;
  logic [7:0]  data    = 8'h00;
  logic        enable  = 1'b0;

  logic [1:0]  virtual_channel;
  logic [5:0]  data_type;
  logic [15:0] word_count;
  logic [7:0]  ecc;
  logic        header_valid, payload_enable, payload_last;
  logic        crc_valid, crc_error, packet_abort;
  logic [7:0]  payload_data;

  logic [1:0]  nc_virtual_channel;
  logic [5:0]  nc_data_type;
  logic [15:0] nc_word_count;
  logic [7:0]  nc_ecc;
  logic        nc_header_valid, nc_payload_enable, nc_payload_last;
  logic        nc_crc_valid, nc_crc_error, nc_packet_abort;
  logic [7:0]  nc_payload_data;

  csi2_packet_parser #(.CHECK_CRC(1'b1)) dut (
    .clock_p(clock_p), .reset(reset), .data(data), .enable(enable),
    .virtual_channel(virtual_channel), .data_type(data_type),
    .word_count(word_count), .ecc(ecc), .header_valid(header_valid),
    .payload_data(payload_data), .payload_enable(payload_enable),
    .payload_last(payload_last), .crc_valid(crc_valid),
    .crc_error(crc_error), .packet_abort(packet_abort)
  );

  csi2_packet_parser #(.CHECK_CRC(1'b0)) dut_nc (
    .clock_p(clock_p), .reset(reset), .data(data), .enable(enable),
    .virtual_channel(nc_virtual_channel), .data_type(nc_data_type),
    .word_count(nc_word_count), .ecc(nc_ecc), .header_valid(nc_header_valid),
    .payload_data(nc_payload_data), .payload_enable(nc_payload_enable),
    .payload_last(nc_payload_last), .crc_valid(nc_crc_valid),
    .crc_error(nc_crc_error), .packet_abort(nc_packet_abort)
  );

  always #5 clock_p = ~clock_p;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic [7:0]  ecc;
  } hdr_t;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
  } pay_t;

  hdr_t       hdr_q[$];
  pay_t       pay_q[$];
  logic       crc_q[$];
  int         abort_pending = 0;
  logic [7:0] tx[$];
  logic [7:0] vec[24];

  hdr_t       mon_h;
  pay_t       mon_p;
  logic       mon_c;

  // Monitor: every output event must match the head of its queue.
  always @(negedge clock_p) begin
    if (!reset) begin
      if (header_valid) begin
        check("hdr_expected", hdr_q.size() != 0, 1'b1);
        if (hdr_q.size() != 0) begin
          mon_h = hdr_q.pop_front();
          check("hdr_fields", {virtual_channel, data_type, word_count, ecc}, mon_h);
        end
      end
      if (payload_enable) begin
        check("pay_expected", pay_q.size() != 0, 1'b1);
        if (pay_q.size() != 0) begin
          mon_p = pay_q.pop_front();
          check("pay_byte", {payload_data, payload_last}, mon_p);
        end
      end else if (payload_last) begin
        check("last_without_enable", payload_last, 1'b0);
      end
      if (crc_valid) begin
        check("crc_expected", crc_q.size() != 0, 1'b1);
        check("crc_with_payload", payload_enable, 1'b0);
        if (crc_q.size() != 0) begin
          mon_c = crc_q.pop_front();
          check("crc_error", crc_error, mon_c);
        end
      end
      if (packet_abort) begin
        check("abort_expected", abort_pending > 0, 1'b1);
        if (abort_pending > 0) abort_pending--;
      end
      // The CRC-disabled instance must match everywhere except crc_error.
      check("nc_mirror",
            {nc_header_valid, nc_payload_last, nc_packet_abort, nc_virtual_channel,
             nc_data_type, nc_word_count, nc_ecc, nc_payload_enable, nc_payload_data},
            {header_valid, payload_last, packet_abort, virtual_channel,
             data_type, word_count, ecc, payload_enable, payload_data});
      if (crc_valid || nc_crc_valid) begin
        check("nc_crc_valid", nc_crc_valid, crc_valid);
        check("nc_crc_error", nc_crc_error, 1'b0);
      end
    end
  end

  task automatic exp_hdr(input logic [7:0] di, input logic [15:0] wc,
                         input logic [7:0] e);
    hdr_q.push_back({di, wc, e});
  endtask

  task automatic exp_pay(input logic [7:0] b, input logic last);
    pay_q.push_back({b, last});
  endtask

  // Drive the first n bytes of tx (all when n < 0), drop enable, idle.
  task automatic play(input int n);
    int lim;
    lim = (n < 0) ? tx.size() : n;
    for (int i = 0; i < lim; i++) begin
      @(negedge clock_p);
      data   = tx[i];
      enable = 1'b1;
    end
    @(negedge clock_p);
    enable = 1'b0;
    data   = 8'h00;
    repeat (3) @(negedge clock_p);
    tx.delete();
  endtask

  // 24-byte CSI-2 CRC reference packet with a chosen CRC LSB.
  task automatic long_vec(input logic [7:0] crc_lsb, input logic err);
    tx = '{8'h2A, 8'h18, 8'h00, 8'h00};
    for (int i = 0; i < 24; i++) tx.push_back(vec[i]);
    tx.push_back(crc_lsb);
    tx.push_back(8'h00);
    tx.push_back(8'hA5);
    tx.push_back(8'h5A);
    exp_hdr(8'h2A, 16'd24, 8'h00);
    for (int i = 0; i < 24; i++) exp_pay(vec[i], i == 23);
    crc_q.push_back(err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
            8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
            8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

    // Reset state.
    repeat (2) @(negedge clock_p);
    check("reset_hdr_fields", {virtual_channel, data_type, word_count, ecc}, 64'h0);
    check("reset_flags", {header_valid, payload_data, payload_enable, payload_last,
                          crc_valid, crc_error, packet_abort}, 64'h0);
    #2 reset = 1'b0;
    repeat (2) @(negedge clock_p);

    // Short packet with trailer.
    tx = '{8'h00, 8'h00, 8'h00, 8'h07, 8'hAA, 8'hBB};
    exp_hdr(8'h00, 16'h0000, 8'h07);
    play(-1);

    // Long packet, good CRC, then the same with a corrupted CRC LSB.
    long_vec(8'hF0, 1'b0);
    play(-1);
    long_vec(8'hF1, 1'b1);
    play(-1);

    // Zero-length long packet: CRC must be 0xFFFF.
    tx = '{8'h2A, 8'h00, 8'h00, 8'h5B, 8'hFF, 8'hFF};
    exp_hdr(8'h2A, 16'h0000, 8'h5B);
    crc_q.push_back(1'b0);
    play(-1);

    // Truncation inside the header.
    tx = '{8'h2A, 8'h08};
    abort_pending++;
    play(-1);

    // Truncation after 3 of 8 payload bytes, then a normal short packet.
    tx = '{8'h2A, 8'h08, 8'h00, 8'h11, 8'h11, 8'h22, 8'h33};
    exp_hdr(8'h2A, 16'd8, 8'h11);
    exp_pay(8'h11, 1'b0);
    exp_pay(8'h22, 1'b0);
    exp_pay(8'h33, 1'b0);
    abort_pending++;
    play(-1);
    tx = '{8'hC5, 8'h34, 8'h12, 8'h3F, 8'h99};
    exp_hdr(8'hC5, 16'h1234, 8'h3F);
    play(-1);

    // Truncation after one CRC byte of a zero-length packet.
    tx = '{8'h2A, 8'h00, 8'h00, 8'h5B, 8'hFF};
    exp_hdr(8'h2A, 16'h0000, 8'h5B);
    abort_pending++;
    play(-1);

    // Reset during PAYLOAD, released while the burst is still running.
    tx = '{8'h2A, 8'h08, 8'h00, 8'h22, 8'h11, 8'h22, 8'h33};
    exp_hdr(8'h2A, 16'd8, 8'h22);
    exp_pay(8'h11, 1'b0);
    exp_pay(8'h22, 1'b0);
    exp_pay(8'h33, 1'b0);
    for (int i = 0; i < tx.size(); i++) begin
      @(negedge clock_p);
      data   = tx[i];
      enable = 1'b1;
    end
    tx.delete();
    @(negedge clock_p);
    #2 reset = 1'b1;
    #1;
    check("midrst_hdr_fields", {virtual_channel, data_type, word_count, ecc}, 64'h0);
    check("midrst_flags", {header_valid, payload_data, payload_enable, payload_last,
                           crc_valid, crc_error, packet_abort}, 64'h0);
    data = 8'h00;
    repeat (2) @(negedge clock_p);
    #2 reset = 1'b0;
    // Enable stays high: these bytes look like a short header but must be drained.
    repeat (5) @(negedge clock_p);
    enable = 1'b0;
    repeat (3) @(negedge clock_p);
    long_vec(8'hF0, 1'b0);
    play(-1);

    repeat (5) @(negedge clock_p);
    check("hdr_q_empty", hdr_q.size(), 0);
    check("pay_q_empty", pay_q.size(), 0);
    check("crc_q_empty", crc_q.size(), 0);
    check("abort_all_seen", abort_pending, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csi2_packet_parser.md
CSI2_PACKET_PARSER -- requirements
Module: csi2_packet_parser

Interface
REQ-001 The block SHALL have parameter CHECK_CRC, default 1; 1 enables payload CRC-16 checking, 0 forces crc_error to 0.
REQ-002 The block SHALL have port clock_p, input, 1 bit: byte clock, the same domain that drives the D-PHY receiver byte output; all logic is on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port data, input, 8 bits: lane byte from the D-PHY receiver.
REQ-005 The block SHALL have port enable, input, 1 bit: data valid; high continuously for the duration of one HS burst.
REQ-006 The block SHALL have port virtual_channel, output, 2 bits: DI[7:6] of the last header.
REQ-007 The block SHALL have port data_type, output, 6 bits: DI[5:0] of the last header.
REQ-008 The block SHALL have port word_count, output, 16 bits: header bytes 1 (LSB) and 2 (MSB).
REQ-009 The block SHALL have port ecc, output, 8 bits: header byte 3, raw and unchecked.
REQ-010 The block SHALL have port header_valid, output, 1 bit: single-cycle pulse when the header fields update.
REQ-011 The block SHALL have port payload_data, output, 8 bits: payload byte.
REQ-012 The block SHALL have port payload_enable, output, 1 bit: payload_data valid.
REQ-013 The block SHALL have port payload_last, output, 1 bit: high with the final payload byte.
REQ-014 The block SHALL have port crc_valid, output, 1 bit: single-cycle pulse when crc_error is meaningful.
REQ-015 The block SHALL have port crc_error, output, 1 bit: received CRC differs from computed CRC.
REQ-016 The block SHALL have port packet_abort, output, 1 bit: single-cycle pulse when a packet is truncated.

Function
REQ-017 The FSM SHALL have states IDLE, HEADER, PAYLOAD, CRC and DRAIN.
- IDLE→HEADER on enable.
- DRAIN→IDLE on !enable.
REQ-018 In HEADER, the block SHALL capture the first 4 enabled bytes as DI, WC_LSB, WC_MSB, ECC.
REQ-019 The header outputs SHALL update and header_valid SHALL pulse on the cycle after the 4th header byte is sampled (latency 1).
REQ-020 A data_type of 0x00-0x0F (short packet) SHALL go HEADER→DRAIN, with no payload or CRC activity.
REQ-021 A data_type of 0x10 or above (long packet) SHALL go HEADER→PAYLOAD, or directly to CRC when word_count==0.
REQ-022 In PAYLOAD, each enabled byte SHALL be re-emitted registered on payload_data/payload_enable with latency 1; the byte count is 16-bit.
REQ-023 payload_last SHALL assert with byte number word_count, then PAYLOAD→CRC.
REQ-024 In CRC, the block SHALL take 2 bytes, LSB first.
- crc_valid SHALL pulse 1 cycle after the 2nd byte, then the FSM goes to DRAIN.
REQ-025 The CRC SHALL be CRC-16 with polynomial x^16+x^12+x^5+1, init 0xFFFF, processed LSB-first, no final XOR, over payload bytes only.
- It SHALL reinit at each header.
- word_count==0 expects 0xFFFF.
REQ-026 In DRAIN, all enabled bytes (trailer) SHALL be ignored.
REQ-027 If enable is low on any cycle in HEADER, PAYLOAD or CRC, the block SHALL:
- pulse packet_abort on the next cycle;
- emit no crc_valid;
- return to IDLE.
- Already-emitted payload bytes are not retracted, and payload_last is not produced.
REQ-028 enable low in IDLE SHALL have no effect.
- A new burst SHALL always start in HEADER, so one packet is parsed per burst.
REQ-029 Header outputs SHALL hold their values until the next header_valid.
- payload_data SHALL hold its last value when payload_enable is low.
REQ-030 header_valid, payload_enable, payload_last, crc_valid and packet_abort SHALL never be high for more than one cycle per event.
- They SHALL be mutually consistent: crc_valid is never in the same cycle as payload_enable.

Reset
REQ-031 While reset is high, the block SHALL asynchronously force:
- state to IDLE;
- all counters and CRC to 0;
- all outputs to 0.
REQ-032 Reset mid-packet SHALL discard the packet without packet_abort.
- After release, the block SHALL wait for the next rising of enable from IDLE: if enable is already high at release, the block enters DRAIN until enable falls.

Verification
REQ-033 Short packet: burst 0x00,0x00,0x00,0x07 then 2 trailer bytes → header_valid once, data_type=0x00, word_count=0, ecc=0x07; no payload_enable or crc_valid.
REQ-034 Long packet, CSI-2 CRC vector, 24-byte payload:
- Header 0x2A,0x18,0x00,0x00.
- Payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01.
- CRC bytes 0xF0,0x00.
- Required response: data_type=0x2A, word_count=24, 24 payload_enable cycles matching the payload in order, payload_last on the 24th, crc_valid with crc_error=0.
REQ-035 Same as REQ-034 with the CRC LSB 0xF1 → crc_error=1 with CHECK_CRC=1, crc_error=0 with CHECK_CRC=0.
REQ-036 Zero-length long packet: 0x2A,0x00,0x00,ECC,0xFF,0xFF → no payload_enable, crc_valid with crc_error=0.
REQ-037 Truncation: long header with WC=8, enable dropped after 3 payload bytes → 3 payload bytes, packet_abort pulse, no payload_last or crc_valid, state IDLE; the next burst parses normally.
REQ-038 Reset asserted during PAYLOAD → all outputs 0 immediately, state IDLE; a following complete packet parses correctly.
